// File: rtl/seven_segment_capture_scan.sv
// Seven-segment adapter: captures lab_top's multiplexed {abcdefgh, digit}
// stream into sticky per-digit registers, drives them onto static display
// buses, and rescans them onto a multiplexed display with ghost-suppression
// blanking and PWM brightness.
module seven_segment_capture_scan #(
  parameter int w_digit          = 4,
  parameter int slot_cycles      = 12500,
  parameter int blank_cycles     = 16,
  parameter int w_brightness     = 4,
  parameter bit seg_active_low   = 1'b1,
  parameter bit digit_active_low = 1'b0,
  parameter bit reverse_bits     = 1'b1,
  localparam int IDX_W = (w_digit > 1) ? $clog2(w_digit) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              abcdefgh,
  input  logic [w_digit-1:0]      digit,
  input  logic                    clear,
  input  logic [w_brightness-1:0] brightness,
  output logic [8*w_digit-1:0]    static_seg,
  output logic [7:0]              scan_seg,
  output logic [w_digit-1:0]      scan_digit,
  output logic [IDX_W-1:0]        scan_index
);

  localparam int SLOT_W  = $clog2(slot_cycles + 1);
  localparam int PH_W    = SLOT_W;
  localparam int PROD_W  = SLOT_W + w_brightness;
  localparam int ON_SPAN = slot_cycles - blank_cycles;

  localparam logic [7:0]         SEG_OFF = seg_active_low ? 8'hFF : 8'h00;
  localparam logic [w_digit-1:0] DIG_OFF = digit_active_low ? '1 : '0;

  // Bit order and polarity applied to a captured pattern before it hits pins.
  function automatic logic [7:0] fmt_seg(input logic [7:0] raw);
    logic [7:0] ordered;
    for (int b = 0; b < 8; b++) begin
      ordered[b] = reverse_bits ? raw[7-b] : raw[b];
    end
    return seg_active_low ? ~ordered : ordered;
  endfunction

  logic [7:0]              cap_p1 [w_digit];
  logic [PH_W-1:0]         phase_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [w_brightness-1:0] b_lat_p0;
  logic [w_brightness-1:0] b_eff_p0;
  logic [PROD_W-1:0]       span_prod_p0;
  logic [PROD_W-1:0]       on_len_p0;
  logic [PROD_W-1:0]       phase_ext_p0;
  logic                    lit_p0;

  // ---- stage p1: sticky capture; clear beats a same-cycle capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < w_digit; i++) cap_p1[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < w_digit; i++) cap_p1[i] <= '0;
    end else begin
      for (int i = 0; i < w_digit; i++) begin
        if (digit[i]) cap_p1[i] <= abcdefgh;
      end
    end
  end

  // ---- stage p2: static per-digit output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      static_seg <= {w_digit{SEG_OFF}};
    end else begin
      for (int i = 0; i < w_digit; i++) static_seg[8*i +: 8] <= fmt_seg(cap_p1[i]);
    end
  end

  // Slot phase counter, digit index and brightness latched at slot start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_p0 <= '0;
      idx_p0   <= '0;
      b_lat_p0 <= '0;
    end else begin
      if (phase_p0 == '0) b_lat_p0 <= brightness;
      if (phase_p0 == PH_W'(slot_cycles - 1)) begin
        phase_p0 <= '0;
        idx_p0   <= (idx_p0 == IDX_W'(w_digit - 1)) ? '0 : idx_p0 + 1'b1;
      end else begin
        phase_p0 <= phase_p0 + 1'b1;
      end
    end
  end

  // ---- stage p0: decode BLANK / ON / DARK from the current phase.
  // At phase 0 the latch is being loaded this cycle, so use the live input
  // so a zero-length blank still sees the new slot's brightness.
  always_comb begin
    b_eff_p0     = (phase_p0 == '0) ? brightness : b_lat_p0;
    span_prod_p0 = PROD_W'(ON_SPAN) * PROD_W'(b_eff_p0);
    if (&b_eff_p0) on_len_p0 = PROD_W'(ON_SPAN);
    else           on_len_p0 = span_prod_p0 >> w_brightness;
    phase_ext_p0 = PROD_W'(phase_p0);
    lit_p0 = (phase_ext_p0 >= PROD_W'(blank_cycles)) &&
             (phase_ext_p0 <  PROD_W'(blank_cycles) + on_len_p0);
  end

  // ---- stage p1: registered scan outputs, index kept aligned with enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_digit <= DIG_OFF;
      scan_seg   <= SEG_OFF;
      scan_index <= '0;
    end else begin
      scan_index <= idx_p0;
      if (lit_p0) begin
        scan_digit <= DIG_OFF ^ (w_digit'(1) << idx_p0);
        scan_seg   <= fmt_seg(cap_p1[idx_p0]);
      end else begin
        scan_digit <= DIG_OFF;
        scan_seg   <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture_scan.sv
// Bench for seven_segment_capture_scan: directed steps plus random traffic,
// every cycle compared with a time-based reference model of the display.
module tb_seven_segment_capture_scan;

  localparam int ND    = 4;
  localparam int SLOT  = 16;
  localparam int BLANK = 2;
  localparam int WB    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    abcdefgh = '0;
  logic [ND-1:0] digit = '0;
  logic          clear = 1'b0;
  logic [WB-1:0] brightness = 4'hF;
  logic [8*ND-1:0] static_seg;
  logic [7:0]      scan_seg;
  logic [ND-1:0]   scan_digit;
  logic [1:0]      scan_index;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         t = 0;
  logic [7:0] capm [ND];
  logic [3:0] blat_m = '0;

  seven_segment_capture_scan #(
    .w_digit(ND), .slot_cycles(SLOT), .blank_cycles(BLANK), .w_brightness(WB),
    .seg_active_low(1'b1), .digit_active_low(1'b0), .reverse_bits(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .abcdefgh(abcdefgh), .digit(digit), .clear(clear),
    .brightness(brightness), .static_seg(static_seg), .scan_seg(scan_seg),
    .scan_digit(scan_digit), .scan_index(scan_index)
  );

  always #5 clk = ~clk;

  // Pin view of a captured pattern: hgfedcba order, lit = 0.
  function automatic logic [7:0] fmt(input logic [7:0] x);
    logic [7:0] r;
    r = {<<{x}};
    return ~r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_static"}, static_seg, 32'hFFFF_FFFF);
    chk({tag, "_digit"}, 32'(scan_digit), 32'h0);
    chk({tag, "_seg"}, 32'(scan_seg), 32'hFF);
    chk({tag, "_index"}, 32'(scan_index), 32'h0);
  endtask

  // One clock: predict outputs from the model, advance model, compare.
  task automatic cyc();
    int ph, idx, onl;
    bit lit;
    logic [31:0] e_static;
    logic [3:0]  e_digit;
    logic [7:0]  e_seg;
    if (t % SLOT == 0) blat_m = brightness;
    ph  = t % SLOT;
    idx = (t / SLOT) % ND;
    onl = (blat_m == 4'hF) ? (SLOT - BLANK) : (((SLOT - BLANK) * int'(blat_m)) >> WB);
    lit = (ph >= BLANK) && (ph < BLANK + onl);
    e_digit = lit ? 4'(1 << idx) : 4'h0;
    e_seg   = lit ? fmt(capm[idx]) : 8'hFF;
    for (int i = 0; i < ND; i++) e_static[8*i +: 8] = fmt(capm[i]);
    if (clear) begin
      for (int i = 0; i < ND; i++) capm[i] = 8'h00;
    end else begin
      for (int i = 0; i < ND; i++) if (digit[i]) capm[i] = abcdefgh;
    end
    @(posedge clk);
    t++;
    #1;
    chk("static_seg", static_seg, e_static);
    chk("scan_digit", 32'(scan_digit), 32'(e_digit));
    chk("scan_seg", 32'(scan_seg), 32'(e_seg));
    chk("scan_index", 32'(scan_index), 32'(idx));
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < ND; i++) capm[i] = 8'h00;
  endtask

  task automatic align_phase(input int p);
    for (int k = 0; k < SLOT && (t % SLOT) != p; k++) cyc();
    chk("align_phase", 32'(t % SLOT), 32'(p));
  endtask

  initial begin
    int cnt;
    logic [7:0] pat;
    model_reset();

    // power-on reset, held over several edges
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;
    repeat (40) begin
      abcdefgh = 8'($urandom);
      digit = 4'($urandom);
      cyc();
    end
    digit = '0;

    // asynchronous reset mid-slot
    align_phase(7);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_vals("rst_held");
    end
    rst = 1'b0;
    model_reset();

    // capture and bit order
    abcdefgh = 8'b1110_0000;
    digit = 4'b0010;
    cyc();
    digit = 4'b0000;
    abcdefgh = 8'h5A;
    cyc();
    chk("cap_d1", 32'(static_seg[15:8]), 32'hF8);
    repeat (20) cyc();
    chk("cap_hold", static_seg, 32'hFFFF_F8FF);

    // multi-hot capture, then clear beating a capture
    abcdefgh = 8'hFF;
    digit = 4'b1001;
    cyc();
    digit = 4'b0000;
    cyc();
    chk("multihot", static_seg, 32'h00FF_F800);
    clear = 1'b1;
    digit = 4'b0100;
    abcdefgh = 8'h81;
    cyc();
    clear = 1'b0;
    digit = 4'b0000;
    cyc();
    chk("clear_wins", static_seg, 32'hFFFF_FFFF);

    // full brightness scan with distinct digit patterns
    for (int i = 0; i < ND; i++) begin
      abcdefgh = 8'(8'h11 << i) | 8'h80;
      digit = 4'(1 << i);
      cyc();
    end
    digit = '0;
    brightness = 4'hF;
    align_phase(0);
    for (int s = 0; s < ND + 1; s++) begin
      cnt = 0;
      for (int k = 0; k < SLOT; k++) begin
        cyc();
        if (scan_digit != 0) cnt++;
      end
      chk("full_lit_cnt", 32'(cnt), 32'd14);
    end

    // PWM levels
    brightness = 4'd8;
    align_phase(0);
    cnt = 0;
    for (int k = 0; k < SLOT; k++) begin
      cyc();
      if (scan_digit != 0) cnt++;
    end
    chk("pwm8_cnt", 32'(cnt), 32'd7);
    brightness = 4'd0;
    cnt = 0;
    for (int k = 0; k < SLOT; k++) begin
      cyc();
      if (scan_digit != 0) cnt++;
    end
    chk("pwm0_cnt", 32'(cnt), 32'd0);

    // brightness change mid-slot takes effect next slot
    brightness = 4'd8;
    cnt = 0;
    for (int k = 0; k < SLOT; k++) begin
      if (t % SLOT == 5) brightness = 4'hF;
      cyc();
      if (scan_digit != 0) cnt++;
    end
    chk("pwm_mid_cur", 32'(cnt), 32'd7);
    cnt = 0;
    for (int k = 0; k < SLOT; k++) begin
      cyc();
      if (scan_digit != 0) cnt++;
    end
    chk("pwm_mid_next", 32'(cnt), 32'd14);

    // live update of the digit currently lit
    for (int k = 0; k < 4 * SLOT && !(((t / SLOT) % ND) == 2 && (t % SLOT) == 6); k++) cyc();
    chk("live_align", 32'(((t / SLOT) % ND) * SLOT + (t % SLOT)), 32'(2 * SLOT + 6));
    pat = 8'b0011_0110;
    abcdefgh = pat;
    digit = 4'b0100;
    cyc();
    digit = '0;
    cyc();
    chk("live_seg", 32'(scan_seg), 32'(fmt(pat)));
    chk("live_digit", 32'(scan_digit), 32'b0100);
    repeat (2 * SLOT) cyc();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      abcdefgh = 8'($urandom);
      digit = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) brightness = 4'($urandom);
      cyc();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
